// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage.
// Included by the sequencer and the memory_cycle top.
package mem_pkg;

    localparam int DATA_W     = 32;
    localparam int VLEN_WORDS = 4;
    localparam int VEC_W      = DATA_W * VLEN_WORDS;
    localparam int REG_ADDR_W = 6;
    localparam int BEAT_W     = $clog2(VLEN_WORDS + 1);
    localparam int LANE_W     = $clog2(VLEN_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE
    } mem_state_t;

    typedef logic [VLEN_WORDS-1:0][DATA_W-1:0] vec_t;

    typedef struct packed {
        logic                  regwrite;
        logic                  memwrite;
        logic                  resultsrc;
        logic                  vec;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     pc4;
        logic [DATA_W-1:0]     alu;
        vec_t                  wdata;
    } instr_t;

    // Address of beat k: base + 4k, wrapping modulo 2^32.
    function automatic logic [DATA_W-1:0] beat_addr(
        input logic [DATA_W-1:0] base,
        input logic [BEAT_W-1:0] k
    );
        return base + (DATA_W'(k) << 2);
    endfunction

endpackage

// File: rtl/memory_cycle_vec_beat_sequencer.sv
// Beat sequencer: FSM, beat counter, address generation and stall.
// Outputs are forced low while reset is held.
module vec_beat_sequencer
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              store,
    input  logic              vec,
    input  logic [DATA_W-1:0] addr_in,
    output logic [DATA_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic              dmem_re,
    output logic              stall,
    output logic              busy,
    output logic              capture,
    output logic              done,
    output logic [BEAT_W-1:0] beat
);

    mem_state_t        state, state_n;
    logic [BEAT_W-1:0] cnt, cnt_n;
    logic [BEAT_W-1:0] beats, beats_n;
    logic [DATA_W-1:0] base, base_n;
    logic [DATA_W-1:0] addr_c;
    logic              we_c, re_c, stall_c, cap_c, done_c;

    // State, beat counter, beat total and latched base address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            beats <= '0;
            base  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            beats <= beats_n;
            base  <= base_n;
        end
    end

    // Next-state, beat addressing and strobes.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        beats_n = beats;
        base_n  = base;
        addr_c  = '0;
        we_c    = 1'b0;
        re_c    = 1'b0;
        stall_c = 1'b0;
        cap_c   = 1'b0;
        done_c  = 1'b0;
        unique case (state)
            IDLE: begin
                base_n = {addr_in[DATA_W-1:2], 2'b00};
                if (load) begin
                    re_c    = 1'b1;
                    addr_c  = base_n;
                    stall_c = 1'b1;
                    state_n = LOAD;
                    cnt_n   = BEAT_W'(1);
                    beats_n = vec ? BEAT_W'(VLEN_WORDS) : BEAT_W'(1);
                end else if (store && vec) begin
                    we_c    = 1'b1;
                    addr_c  = base_n;
                    stall_c = 1'b1;
                    state_n = STORE;
                    cnt_n   = BEAT_W'(1);
                end else if (store) begin
                    we_c   = 1'b1;
                    addr_c = base_n;
                    done_c = 1'b1;
                end else begin
                    done_c = 1'b1;
                end
            end
            LOAD: begin
                cap_c = 1'b1;
                if (cnt == beats) begin
                    done_c  = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    re_c    = 1'b1;
                    addr_c  = beat_addr(base, cnt);
                    stall_c = 1'b1;
                    cnt_n   = cnt + BEAT_W'(1);
                end
            end
            STORE: begin
                we_c   = 1'b1;
                addr_c = beat_addr(base, cnt);
                if (cnt == BEAT_W'(VLEN_WORDS - 1)) begin
                    done_c  = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    stall_c = 1'b1;
                    cnt_n   = cnt + BEAT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign dmem_addr = rst ? '0 : addr_c;
    assign dmem_we   = we_c & ~rst;
    assign dmem_re   = re_c & ~rst;
    assign stall     = stall_c & ~rst;
    assign capture   = cap_c & ~rst;
    assign done      = done_c & ~rst;
    assign busy      = (state != IDLE);
    assign beat      = cnt;

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: scalar and 128-bit vector data-memory access,
// read-buffer assembly and the memory-to-writeback register.
module memory_cycle
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic                  MemWriteM,
    input  logic                  ResultSrcM,
    input  logic                  is_vectorialM,
    input  logic [REG_ADDR_W-1:0] RD_M,
    input  logic [DATA_W-1:0]     PCPlus4M,
    input  logic [DATA_W-1:0]     ALU_ResultM,
    input  logic [VEC_W-1:0]      WriteDataM,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    output logic                  dmem_we,
    output logic                  dmem_re,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  StallM,
    output logic                  RegWriteW,
    output logic                  ResultSrcW,
    output logic                  is_vectorialW,
    output logic [REG_ADDR_W-1:0] RD_W,
    output logic [DATA_W-1:0]     PCPlus4W,
    output logic [DATA_W-1:0]     ALU_ResultW,
    output logic [VEC_W-1:0]      ReadDataW,
    output logic                  MisalignW
);

    instr_t            cur, lat, src;
    logic              busy, capture, done, is_load;
    logic [BEAT_W-1:0] beat;
    logic [LANE_W-1:0] rlane, wlane;
    vec_t              rbuf, rbuf_n;

    // Bundle the incoming M-stage fields.
    always_comb begin
        cur           = '0;
        cur.regwrite  = RegWriteM;
        cur.memwrite  = MemWriteM;
        cur.resultsrc = ResultSrcM;
        cur.vec       = is_vectorialM;
        cur.rd        = RD_M;
        cur.pc4       = PCPlus4M;
        cur.alu       = ALU_ResultM;
        cur.wdata     = WriteDataM;
    end

    vec_beat_sequencer u_seq (
        .clk       (clk),
        .rst       (rst),
        .load      (ResultSrcM & ~MemWriteM),
        .store     (MemWriteM),
        .vec       (is_vectorialM),
        .addr_in   (ALU_ResultM),
        .dmem_addr (dmem_addr),
        .dmem_we   (dmem_we),
        .dmem_re   (dmem_re),
        .stall     (StallM),
        .busy      (busy),
        .capture   (capture),
        .done      (done),
        .beat      (beat)
    );

    assign src     = busy ? lat : cur;
    assign is_load = src.resultsrc & ~src.memwrite;
    assign rlane   = LANE_W'(beat - BEAT_W'(1));
    assign wlane   = beat[LANE_W-1:0];

    assign dmem_wdata = dmem_we ? src.wdata[wlane] : '0;

    // Merge the beat arriving this cycle into the read buffer.
    always_comb begin
        rbuf_n = rbuf;
        if (capture) begin
            rbuf_n[rlane] = dmem_rdata;
        end
    end

    // Latch the instruction while idle; hold it for multi-beat ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat  <= '0;
            rbuf <= '0;
        end else begin
            if (!busy) begin
                lat <= cur;
            end
            rbuf <= rbuf_n;
        end
    end

    // Writeback register: load on completion, bubble otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW     <= 1'b0;
            ResultSrcW    <= 1'b0;
            is_vectorialW <= 1'b0;
            RD_W          <= '0;
            PCPlus4W      <= '0;
            ALU_ResultW   <= '0;
            ReadDataW     <= '0;
            MisalignW     <= 1'b0;
        end else if (done) begin
            RegWriteW     <= src.regwrite & ~src.memwrite;
            ResultSrcW    <= src.resultsrc;
            is_vectorialW <= src.vec;
            RD_W          <= src.rd;
            PCPlus4W      <= src.pc4;
            ALU_ResultW   <= src.alu;
            MisalignW     <= |src.alu[1:0];
            if (!is_load) begin
                ReadDataW <= '0;
            end else if (src.vec) begin
                ReadDataW <= rbuf_n;
            end else begin
                ReadDataW <= {{(VEC_W-DATA_W){1'b0}}, dmem_rdata};
            end
        end else begin
            RegWriteW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle with a behavioural data memory
// (1-cycle read latency) and a log of every write strobe.
module tb_memory_cycle;

    logic         clk = 1'b0;
    logic         rst;
    logic         RegWriteM, MemWriteM, ResultSrcM, is_vectorialM;
    logic [5:0]   RD_M;
    logic [31:0]  PCPlus4M, ALU_ResultM;
    logic [127:0] WriteDataM;
    logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic         dmem_we, dmem_re, StallM;
    logic         RegWriteW, ResultSrcW, is_vectorialW, MisalignW;
    logic [5:0]   RD_W;
    logic [31:0]  PCPlus4W, ALU_ResultW;
    logic [127:0] ReadDataW;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_a [$];
    logic [31:0] wr_d [$];

    memory_cycle dut (
        .clk           (clk),
        .rst           (rst),
        .RegWriteM     (RegWriteM),
        .MemWriteM     (MemWriteM),
        .ResultSrcM    (ResultSrcM),
        .is_vectorialM (is_vectorialM),
        .RD_M          (RD_M),
        .PCPlus4M      (PCPlus4M),
        .ALU_ResultM   (ALU_ResultM),
        .WriteDataM    (WriteDataM),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_we       (dmem_we),
        .dmem_re       (dmem_re),
        .dmem_rdata    (dmem_rdata),
        .StallM        (StallM),
        .RegWriteW     (RegWriteW),
        .ResultSrcW    (ResultSrcW),
        .is_vectorialW (is_vectorialW),
        .RD_W          (RD_W),
        .PCPlus4W      (PCPlus4W),
        .ALU_ResultW   (ALU_ResultW),
        .ReadDataW     (ReadDataW),
        .MisalignW     (MisalignW)
    );

    always #5 clk = ~clk;

    // Behavioural memory: registered read, write log.
    always @(posedge clk) begin
        if (dmem_re) begin
            dmem_rdata <= mem.exists(dmem_addr) ? mem[dmem_addr] : 32'h0;
        end
        if (dmem_we) begin
            wr_a.push_back(dmem_addr);
            wr_d.push_back(dmem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mw, input logic rs,
                         input logic vec, input logic [5:0] rd,
                         input logic [31:0] alu, input logic [127:0] wd);
        RegWriteM     = rw;
        MemWriteM     = mw;
        ResultSrcM    = rs;
        is_vectorialM = vec;
        RD_M          = rd;
        ALU_ResultM   = alu;
        PCPlus4M      = alu + 32'h1000;
        WriteDataM    = wd;
    endtask

    initial begin
        dmem_rdata = 32'h0;
        mem[32'h40]  = 32'hDEADBEEF;
        mem[32'h100] = 32'h1;
        mem[32'h104] = 32'h2;
        mem[32'h108] = 32'h3;
        mem[32'h10C] = 32'h4;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_regwrite", RegWriteW, 0);
        chk("rst_stall", StallM, 0);
        chk("rst_we_re", {dmem_we, dmem_re}, 0);
        chk("rst_readdata", ReadDataW, 0);
        rst = 1'b0;

        // ALU pass-through
        drive(1, 0, 0, 0, 5, 30, 0);
        #1;
        chk("alu_stall", StallM, 0);
        chk("alu_strobes", {dmem_we, dmem_re}, 0);
        tick();
        chk("alu_regwrite", RegWriteW, 1);
        chk("alu_result", ALU_ResultW, 30);
        chk("alu_rd", RD_W, 5);
        chk("alu_pc4", PCPlus4W, 32'h101E);

        // Scalar load from 0x40, back-to-back after the ALU op
        drive(1, 0, 1, 0, 7, 32'h40, 0);
        #1;
        chk("sld_c0", {StallM, dmem_re, dmem_addr}, {2'b11, 32'h40});
        tick();
        chk("sld_c1", {StallM, dmem_re}, 0);
        chk("sld_bubble", RegWriteW, 0);
        tick();
        chk("sld_regwrite", RegWriteW, 1);
        chk("sld_data", ReadDataW, 128'hDEADBEEF);
        chk("sld_rd_src", {RD_W, ResultSrcW}, {6'd7, 1'b1});
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("sld_pulse", RegWriteW, 0);

        // Vector load from 0x100
        drive(1, 0, 1, 1, 9, 32'h100, 0);
        #1;
        chk("vld_b0", {StallM, dmem_re, dmem_addr}, {2'b11, 32'h100});
        tick();
        chk("vld_b1", {StallM, dmem_re, dmem_addr}, {2'b11, 32'h104});
        tick();
        chk("vld_b2", {StallM, dmem_re, dmem_addr}, {2'b11, 32'h108});
        tick();
        chk("vld_b3", {StallM, dmem_re, dmem_addr}, {2'b11, 32'h10C});
        tick();
        chk("vld_last", {StallM, dmem_re}, 0);
        tick();
        chk("vld_data", ReadDataW,
            128'h00000004_00000003_00000002_00000001);
        chk("vld_flags", {RegWriteW, is_vectorialW, RD_W},
            {2'b11, 6'd9});

        // Vector store wrapping past 2^32
        wr_a.delete();
        wr_d.delete();
        drive(1, 1, 0, 1, 3, 32'hFFFFFFF8,
              128'h11111111_22222222_33333333_44444444);
        #1;
        chk("vst_s0", StallM, 1);
        tick();
        chk("vst_s1", StallM, 1);
        tick();
        chk("vst_s2", StallM, 1);
        tick();
        chk("vst_s3", {StallM, dmem_we}, 2'b01);
        tick();
        chk("vst_nwr", wr_a.size(), 4);
        if (wr_a.size() == 4) begin
            chk("vst_w0", {wr_a[0], wr_d[0]}, {32'hFFFFFFF8, 32'h44444444});
            chk("vst_w1", {wr_a[1], wr_d[1]}, {32'hFFFFFFFC, 32'h33333333});
            chk("vst_w2", {wr_a[2], wr_d[2]}, {32'h00000000, 32'h22222222});
            chk("vst_w3", {wr_a[3], wr_d[3]}, {32'h00000004, 32'h11111111});
        end
        chk("vst_regwrite", RegWriteW, 0);
        chk("vst_alu", ALU_ResultW, 32'hFFFFFFF8);

        // Misaligned scalar store
        drive(1, 1, 0, 0, 4, 32'h43, 128'hCAFEF00D);
        #1;
        chk("mst_bus", {StallM, dmem_we, dmem_addr, dmem_wdata},
            {2'b01, 32'h40, 32'hCAFEF00D});
        tick();
        chk("mst_misalign", MisalignW, 1);
        chk("mst_regwrite", RegWriteW, 0);

        // Reset during beat 2 of a vector load
        drive(1, 0, 1, 1, 9, 32'h100, 0);
        tick();
        tick();
        chk("rvl_b2", {StallM, dmem_addr}, {1'b1, 32'h108});
        rst = 1'b1;
        #1;
        chk("rvl_stall", StallM, 0);
        chk("rvl_bus", {dmem_re, dmem_we, dmem_addr}, 0);
        chk("rvl_w", {RegWriteW, ALU_ResultW, MisalignW}, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(1, 0, 0, 0, 12, 77, 0);
        #1;
        chk("post_stall", StallM, 0);
        tick();
        chk("post_alu", {RegWriteW, RD_W, ALU_ResultW},
            {1'b1, 6'd12, 32'd77});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
